// File: rtl/ddr3_frame_arbiter_if.sv
// DDR3 user command port seen from the frame arbiter: command request,
// ready handshake and the end-of-data-phase pulse.
interface ddr3_frame_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_bl;
    logic              cmd_rdy;
    logic              burst_done;

    modport master (
        output cmd_en, cmd_instr, cmd_addr, cmd_bl,
        input  cmd_rdy, burst_done
    );

    modport slave (
        input  cmd_en, cmd_instr, cmd_addr, cmd_bl,
        output cmd_rdy, burst_done
    );
endinterface

// File: rtl/ddr3_frame_arbiter.sv
// Round-robin write/read burst arbiter for the camera-to-HDMI DDR3 path with
// ping-pong frame banks so the display always reads the last complete frame.
module ddr3_frame_arbiter #(
    parameter int                ADDR_W      = 28,
    parameter int                BURST_LEN   = 64,
    parameter int                FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BANK_STRIDE = ADDR_W'('h0080000)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   init_done,
    input  logic                   wr_frame_start,
    input  logic                   rd_frame_start,
    input  logic [9:0]             wr_fifo_cnt,
    input  logic [9:0]             rd_fifo_space,
    ddr3_frame_arbiter_if.master   cmd,
    output logic                   wr_bank,
    output logic                   rd_bank,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE, ARB, WR_CMD, RD_CMD, WR_WAIT, RD_WAIT
    } state_t;

    localparam logic [2:0]        INSTR_WRITE = 3'b000;
    localparam logic [2:0]        INSTR_READ  = 3'b001;
    localparam logic [9:0]        BURST_CNT   = 10'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END   = ADDR_W'(FRAME_WORDS);

    state_t            state, state_next;
    logic [ADDR_W-1:0] wr_off, rd_off;
    logic              done_bank;
    logic              last_was_read;
    logic              wr_pend, rd_pend;

    logic wr_elig, rd_elig;
    logic apply_starts, grant_wr, grant_rd, wr_fin, rd_fin;
    logic done_bank_upd;

    assign wr_elig = (wr_fifo_cnt >= BURST_CNT) && (wr_off < FRAME_END);
    assign rd_elig = (rd_fifo_space >= BURST_CNT) && (rd_off < FRAME_END);

    // A read start applied together with a write start must see the bank the
    // write start just retired.
    assign done_bank_upd = (wr_pend && wr_off == FRAME_END) ? wr_bank : done_bank;

    assign cmd.cmd_en = (state == WR_CMD) || (state == RD_CMD);
    assign cmd.cmd_bl = 8'(BURST_LEN - 1);
    assign busy       = (state == WR_CMD) || (state == RD_CMD) ||
                        (state == WR_WAIT) || (state == RD_WAIT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every signal assigned here gets a default first, otherwise the
    // branches that skip it would infer a latch.
    always_comb begin
        state_next   = state;
        apply_starts = 1'b0;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        wr_fin       = 1'b0;
        rd_fin       = 1'b0;
        case (state)
            IDLE: if (init_done) state_next = ARB;
            ARB: begin
                // Frame starts take a whole ARB cycle; eligibility is judged
                // on the refreshed offsets the cycle after.
                if (wr_pend || rd_pend) begin
                    apply_starts = 1'b1;
                end else if (init_done) begin
                    if (wr_elig && (!rd_elig || last_was_read)) begin
                        grant_wr   = 1'b1;
                        state_next = WR_CMD;
                    end else if (rd_elig) begin
                        grant_rd   = 1'b1;
                        state_next = RD_CMD;
                    end
                end
            end
            WR_CMD:  if (cmd.cmd_rdy) state_next = WR_WAIT;
            RD_CMD:  if (cmd.cmd_rdy) state_next = RD_WAIT;
            WR_WAIT: if (cmd.burst_done) begin
                wr_fin     = 1'b1;
                state_next = ARB;
            end
            RD_WAIT: if (cmd.burst_done) begin
                rd_fin     = 1'b1;
                state_next = ARB;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cmd.cmd_instr <= INSTR_WRITE;
            cmd.cmd_addr  <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b1;
            done_bank     <= 1'b1;
            wr_off        <= '0;
            rd_off        <= '0;
            last_was_read <= 1'b1;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
        end else begin
            wr_pend <= wr_frame_start | (wr_pend & ~apply_starts);
            rd_pend <= rd_frame_start | (rd_pend & ~apply_starts);

            if (apply_starts && wr_pend) begin
                // A torn frame keeps its bank and is simply overwritten.
                if (wr_off == FRAME_END) begin
                    done_bank <= wr_bank;
                    wr_bank   <= ~wr_bank;
                end
                wr_off <= '0;
            end
            if (apply_starts && rd_pend) begin
                rd_bank <= done_bank_upd;
                rd_off  <= '0;
            end

            if (grant_wr) begin
                cmd.cmd_addr  <= (wr_bank ? BANK_STRIDE : '0) + wr_off;
                cmd.cmd_instr <= INSTR_WRITE;
                last_was_read <= 1'b0;
            end
            if (grant_rd) begin
                cmd.cmd_addr  <= (rd_bank ? BANK_STRIDE : '0) + rd_off;
                cmd.cmd_instr <= INSTR_READ;
                last_was_read <= 1'b1;
            end

            if (wr_fin) wr_off <= wr_off + BURST_STEP;
            if (rd_fin) rd_off <= rd_off + BURST_STEP;
        end
    end

endmodule

// File: tb/tb_ddr3_frame_arbiter.sv
// Directed bench for ddr3_frame_arbiter: expected commands are queued as
// stimulus is set up and popped on each command handshake.
module tb_ddr3_frame_arbiter;

    localparam int ADDR_W = 28;
    localparam logic [2:0] W = 3'b000;
    localparam logic [2:0] R = 3'b001;

    typedef struct {
        logic [2:0]        instr;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       init_done;
    logic       wr_frame_start;
    logic       rd_frame_start;
    logic [9:0] wr_fifo_cnt;
    logic [9:0] rd_fifo_space;
    logic       wr_bank, rd_bank, busy;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ddr3_frame_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    ddr3_frame_arbiter #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (4),
        .FRAME_WORDS (16),
        .BANK_STRIDE (28'h100)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .init_done      (init_done),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .wr_fifo_cnt    (wr_fifo_cnt),
        .rd_fifo_space  (rd_fifo_space),
        .cmd            (bus.master),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .busy           (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] instr, input logic [ADDR_W-1:0] addr);
        cmd_t c;
        c.instr = instr;
        c.addr  = addr;
        exp_q.push_back(c);
    endtask

    // Returns at the falling edge where cmd_en && cmd_rdy is seen; the
    // handshake completes on the following rising edge.
    task automatic wait_cmd(input string tag);
        cmd_t c;
        bit   seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.cmd_en && bus.cmd_rdy) begin
                seen = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        c = exp_q.pop_front();
        check({tag, "_instr"}, 32'(bus.cmd_instr), 32'(c.instr));
        check({tag, "_addr"},  32'(bus.cmd_addr),  32'(c.addr));
        check({tag, "_bl"},    32'(bus.cmd_bl),    32'd3);
        check({tag, "_busy"},  32'(busy),          32'd1);
    endtask

    task automatic end_burst(input string tag);
        @(negedge sys_clk);
        check({tag, "_wait_busy"}, 32'(busy), 32'd1);
        check({tag, "_wait_en"}, 32'(bus.cmd_en), 32'd0);
        bus.burst_done = 1'b1;
        @(negedge sys_clk);
        bus.burst_done = 1'b0;
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        sys_rst        = 1'b1;
        wr_fifo_cnt    = '0;
        rd_fifo_space  = '0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        bus.cmd_rdy    = 1'b1;
        bus.burst_done = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check({tag, "_cmd_en"},  32'(bus.cmd_en),    32'd0);
        check({tag, "_busy"},    32'(busy),          32'd0);
        check({tag, "_wr_bank"}, 32'(wr_bank),       32'd0);
        check({tag, "_rd_bank"}, 32'(rd_bank),       32'd1);
        check({tag, "_addr"},    32'(bus.cmd_addr),  32'd0);
        check({tag, "_instr"},   32'(bus.cmd_instr), 32'd0);
        sys_rst = 1'b0;
    endtask

    task automatic pulse_wr_start();
        wr_frame_start = 1'b1;
        @(negedge sys_clk);
        wr_frame_start = 1'b0;
    endtask

    task automatic pulse_rd_start();
        rd_frame_start = 1'b1;
        @(negedge sys_clk);
        rd_frame_start = 1'b0;
    endtask

    initial begin
        sys_rst        = 1'b1;
        init_done      = 1'b0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        wr_fifo_cnt    = '0;
        rd_fifo_space  = '0;
        bus.cmd_rdy    = 1'b1;
        bus.burst_done = 1'b0;

        // Single write requester: sequential burst addresses.
        do_reset("rst0");
        init_done   = 1'b1;
        wr_fifo_cnt = 10'd4;
        push(W, 28'h000);
        wait_cmd("t1_w0");
        end_burst("t1_w0");
        push(W, 28'h004);
        wait_cmd("t1_w1");
        wr_fifo_cnt = 10'd0;
        end_burst("t1_w1");

        // Both requesters eligible: strict alternation, write first.
        do_reset("rst1");
        wr_fifo_cnt   = 10'd8;
        rd_fifo_space = 10'd8;
        for (int i = 0; i < 4; i++) begin
            push(W, 28'(4 * i));
            push(R, 28'h100 + 28'(4 * i));
        end
        for (int i = 0; i < 8; i++) begin
            wait_cmd("t2_alt");
            end_burst("t2_alt");
        end
        repeat (3) @(negedge sys_clk);
        check("t2_saturated", 32'(bus.cmd_en), 32'd0);

        // Complete frame: bank swap, display follows the finished frame.
        pulse_wr_start();
        push(W, 28'h100);
        wait_cmd("t3_w");
        check("t3_wr_bank", 32'(wr_bank), 32'd1);
        wr_fifo_cnt = 10'd0;
        end_burst("t3_w");
        pulse_rd_start();
        push(R, 28'h000);
        wait_cmd("t3_r");
        check("t3_rd_bank", 32'(rd_bank), 32'd0);
        rd_fifo_space = 10'd0;
        end_burst("t3_r");

        // Torn frame: bank kept, offset restarted, done bank untouched.
        do_reset("rst2");
        wr_fifo_cnt = 10'd4;
        push(W, 28'h000);
        wait_cmd("t4_w0");
        end_burst("t4_w0");
        push(W, 28'h004);
        wait_cmd("t4_w1");
        wr_fifo_cnt = 10'd0;
        end_burst("t4_w1");
        pulse_wr_start();
        repeat (2) @(negedge sys_clk);
        check("t4_wr_bank", 32'(wr_bank), 32'd0);
        check("t4_idle_en", 32'(bus.cmd_en), 32'd0);
        wr_fifo_cnt = 10'd4;
        push(W, 28'h000);
        wait_cmd("t4_w2");
        wr_fifo_cnt = 10'd0;
        end_burst("t4_w2");
        pulse_rd_start();
        rd_fifo_space = 10'd4;
        push(R, 28'h100);
        wait_cmd("t4_r");
        check("t4_rd_bank", 32'(rd_bank), 32'd1);
        rd_fifo_space = 10'd0;
        end_burst("t4_r");

        // Stalled command port, then a frame start held off until burst_done.
        bus.cmd_rdy = 1'b0;
        wr_fifo_cnt = 10'd4;
        for (int i = 0; i < 20 && !bus.cmd_en; i++) @(negedge sys_clk);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_en",   32'(bus.cmd_en),    32'd1);
            check("t5_hold_addr", 32'(bus.cmd_addr),  32'h004);
            check("t5_hold_inst", 32'(bus.cmd_instr), 32'(W));
            @(negedge sys_clk);
        end
        bus.cmd_rdy = 1'b1;
        push(W, 28'h004);
        wait_cmd("t5_w");
        @(negedge sys_clk);
        pulse_wr_start();
        repeat (2) @(negedge sys_clk);
        check("t5_mid_busy", 32'(busy), 32'd1);
        check("t5_mid_bank", 32'(wr_bank), 32'd0);
        bus.burst_done = 1'b1;
        @(negedge sys_clk);
        bus.burst_done = 1'b0;
        check("t5_done_busy", 32'(busy), 32'd0);
        push(W, 28'h000);
        wait_cmd("t5_w_restart");
        wr_fifo_cnt   = 10'd0;
        rd_fifo_space = 10'd4;
        end_burst("t5_w_restart");

        // Reset during a read data phase; nothing issued until init_done.
        push(R, 28'h104);
        wait_cmd("t6_r");
        rd_fifo_space = 10'd0;
        @(negedge sys_clk);
        check("t6_rd_wait_busy", 32'(busy), 32'd1);
        sys_rst   = 1'b1;
        init_done = 1'b0;
        @(negedge sys_clk);
        check("t6_rst_en",      32'(bus.cmd_en), 32'd0);
        check("t6_rst_busy",    32'(busy),       32'd0);
        check("t6_rst_wr_bank", 32'(wr_bank),    32'd0);
        check("t6_rst_rd_bank", 32'(rd_bank),    32'd1);
        sys_rst     = 1'b0;
        wr_fifo_cnt = 10'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("t6_no_init_en", 32'(bus.cmd_en), 32'd0);
        end
        init_done = 1'b1;
        push(W, 28'h000);
        wait_cmd("t6_w");
        wr_fifo_cnt = 10'd0;
        end_burst("t6_w");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
